// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU op codes and buffer-entry flag types
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Status flags stored alongside each result in the output buffer
    typedef struct packed {
        logic zero;
        logic overflow;
        logic illegal_op;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: op code and operands to result and flags
module alu_core
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    output logic [WIDTH-1:0] o_result,
    output alu_flags_t       o_flags
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf_add;
    logic             w_ovf_sub;
    logic             w_slt;

    assign w_sum     = i_src_a + i_src_b;
    assign w_diff    = i_src_a - i_src_b;
    assign w_ovf_add = (i_src_a[WIDTH-1] == i_src_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_src_a[WIDTH-1]);
    assign w_ovf_sub = (i_src_a[WIDTH-1] != i_src_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_src_a[WIDTH-1]);
    // Sign of the difference corrected by overflow keeps SLT right at the extremes
    assign w_slt     = w_diff[WIDTH-1] ^ w_ovf_sub;

    always_comb begin
        o_result           = '0;
        o_flags.overflow   = 1'b0;
        o_flags.illegal_op = 1'b0;
        case (i_op)
            ALU_AND: o_result = i_src_a & i_src_b;
            ALU_OR:  o_result = i_src_a | i_src_b;
            ALU_ADD: begin
                o_result         = w_sum;
                o_flags.overflow = w_ovf_add;
            end
            ALU_SUB: begin
                o_result         = w_diff;
                o_flags.overflow = w_ovf_sub;
            end
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_NOR: o_result = ~(i_src_a | i_src_b);
            default: o_flags.illegal_op = 1'b1;
        endcase
        o_flags.zero = (o_result == '0);
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered execute-stage ALU with main + skid output buffer
module alu_exec_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       aluOperation,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] aluResult,
    output logic             zero,
    output logic             overflow,
    output logic             illegalOp
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        alu_flags_t       flags;
    } entry_t;

    logic [WIDTH-1:0] w_result;
    alu_flags_t       w_flags;
    entry_t           w_new;
    entry_t           r_main;
    entry_t           r_skid;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic             w_accept;
    logic             w_drain;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .i_op    (aluOperation),
        .i_src_a (srcA),
        .i_src_b (srcB),
        .o_result(w_result),
        .o_flags (w_flags)
    );

    assign w_new    = '{result: w_result, flags: w_flags};
    assign inReady  = !r_skid_valid;
    assign w_accept = inValid && !r_skid_valid;
    assign w_drain  = r_main_valid && outReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            // No accept is possible here; only the skid-to-main move on drain
            if (w_drain) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid || w_drain) begin
                r_main       <= w_new;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= w_new;
                r_skid_valid <= 1'b1;
            end
        end else if (w_drain) begin
            r_main_valid <= 1'b0;
        end
    end

    assign outValid  = r_main_valid;
    assign aluResult = r_main.result;
    assign zero      = r_main.flags.zero;
    assign overflow  = r_main.flags.overflow;
    assign illegalOp = r_main.flags.illegal_op;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic [3:0]   aluOperation;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] aluResult;
    logic         zero;
    logic         overflow;
    logic         illegalOp;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         o;
        logic         i;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .inValid     (inValid),
        .inReady     (inReady),
        .aluOperation(aluOperation),
        .srcA        (srcA),
        .srcB        (srcB),
        .outValid    (outValid),
        .outReady    (outReady),
        .aluResult   (aluResult),
        .zero        (zero),
        .overflow    (overflow),
        .illegalOp   (illegalOp)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [W:0]  wide;
        e = '0;
        case (op)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0010: begin
                wide = {a[W-1], a} + {b[W-1], b};
                e.r  = wide[W-1:0];
                e.o  = wide[W] != wide[W-1];
            end
            4'b0110: begin
                wide = {a[W-1], a} - {b[W-1], b};
                e.r  = wide[W-1:0];
                e.o  = wide[W] != wide[W-1];
            end
            4'b0111: e.r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'b1100: e.r = ~(a | b);
            default: e.i = 1'b1;
        endcase
        e.z = (e.r == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        inValid      = 1'b1;
        aluOperation = op;
        srcA         = a;
        srcB         = b;
    endtask

    task automatic idle();
        inValid = 1'b0;
    endtask

    // Checks current outputs against the scoreboard, records accepts, advances one edge
    task automatic tick();
        exp_t e;
        if (outValid) begin
            if (sb.size() == 0) begin
                chk("out_when_empty", {{(W-1){1'b0}}, outValid}, 0);
            end else begin
                e = sb[0];
                chk("result", aluResult, e.r);
                chk("zero", {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, e.z});
                chk("overflow", {{(W-1){1'b0}}, overflow}, {{(W-1){1'b0}}, e.o});
                chk("illegal", {{(W-1){1'b0}}, illegalOp}, {{(W-1){1'b0}}, e.i});
                if (outReady) void'(sb.pop_front());
            end
        end
        if (inValid && inReady) sb.push_back(model(aluOperation, srcA, srcB));
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        idle();
        outReady = 1'b1;
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        reset        = 1'b1;
        inValid      = 1'b0;
        outReady     = 1'b1;
        aluOperation = 4'b0000;
        srcA         = '0;
        srcB         = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_outValid", {31'b0, outValid}, 0);
        chk("rst_inReady", {31'b0, inReady}, 1);
        chk("rst_result", aluResult, 0);
        chk("rst_zero", {31'b0, zero}, 0);
        chk("rst_overflow", {31'b0, overflow}, 0);
        chk("rst_illegal", {31'b0, illegalOp}, 0);

        drive(4'b0010, 5, 7);
        tick();
        idle();
        chk("add_outValid", {31'b0, outValid}, 1);
        chk("add_result", aluResult, 12);
        tick();
        chk("add_drained", {31'b0, outValid}, 0);

        drive(4'b0010, 32'h7FFF_FFFF, 32'h1);        tick();
        drive(4'b0110, 32'h8000_0000, 32'h1);        tick();
        drive(4'b0110, 9, 9);                        tick();
        drive(4'b0111, 32'h8000_0000, 32'h1);        tick();
        drive(4'b0111, 32'h1, 32'h8000_0000);        tick();
        drive(4'b1100, 0, 0);                        tick();
        drive(4'b1111, 32'h1234_5678, 32'h9);        tick();
        drive(4'b0010, 32'hFFFF_FFFF, 32'h2);        tick();
        drive(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00); tick();
        drive(4'b0001, 32'h0F00_0000, 32'h0000_00F0); tick();
        drive(4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF); tick();
        drain_all();

        outReady = 1'b0;
        drive(4'b0010, 100, 1);   tick();
        drive(4'b0110, 50, 60);   tick();
        drive(4'b0001, 3, 4);
        chk("bp_inReady_low", {31'b0, inReady}, 0);
        tick();
        outReady = 1'b1;
        tick();
        chk("bp_inReady_back", {31'b0, inReady}, 1);
        tick();
        drain_all();
        chk("bp_final_inReady", {31'b0, inReady}, 1);

        outReady = 1'b0;
        drive(4'b0010, 1, 1);     tick();
        drive(4'b0000, 3, 5);     tick();
        idle();
        chk("full_inReady", {31'b0, inReady}, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        chk("rst2_outValid", {31'b0, outValid}, 0);
        chk("rst2_inReady", {31'b0, inReady}, 1);
        chk("rst2_result", aluResult, 0);
        outReady = 1'b1;
        repeat (3) tick();
        chk("rst2_still_empty", {31'b0, outValid}, 0);

        drive(4'b0110, 20, 5);
        tick();
        drain_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
